pipelined_carry_adder: RTL and testbench

//   Parametrised, pipelined successor to the 4-bit ripple-carry adder.

---
 rtl/pipelined_carry_adder.sv | 150 +++++++++++++++
 tb/tb_pipelined_carry_adder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_adder.sv
// ---------------------------------------------------------------------------
// pipelined_carry_adder
//
// Parametrised pipelined adder. A WIDTH-bit add is split into STAGES equal
// chunks of CW = WIDTH/STAGES bits. An input rank captures the operands at
// acceptance. Each following stage ripples one chunk and registers the chunk
// sum, its carry-out and the operands that later stages still need.
// A single global enable (adv) moves the whole pipe, so it sustains one add
// per cycle when the consumer keeps out_ready high.
//
// Latency: an operation accepted at edge t shows out_valid=1 after edge
// t+STAGES.
//
// Parameters
//   WIDTH   operand/sum width; must be a multiple of STAGES
//   STAGES  number of ripple stages (= chunks)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands A/B/Cin valid
//   in_ready   operands accepted this cycle (equals adv)
//   A, B       unsigned operands
//   Cin        carry into bit 0
//   out_valid  Sum/Cout valid
//   out_ready  consumer takes the result this cycle
//   Sum        A+B+Cin modulo 2^WIDTH
//   Cout       carry out of bit WIDTH-1
//   Ovf        signed overflow, only when ADD_OVF_EN is defined
//
// Configuration macro: ADD_OVF_EN adds the Ovf port and its register.
// ---------------------------------------------------------------------------
module pipelined_carry_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
`ifdef ADD_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int CW = WIDTH / STAGES;

   // Rank 0 is the input register; rank k+1 holds the result of stage k.
   // Operands are only needed up to the input of the last stage.
   logic [STAGES:0]                v_q;
   logic [STAGES:0]                c_q;
   logic [STAGES:0][WIDTH-1:0]     s_q;
   logic [STAGES-1:0][WIDTH-1:0]   a_q;
   logic [STAGES-1:0][WIDTH-1:0]   b_q;

   // Combinational result of every stage, consumed by the next rank.
   logic [STAGES-1:0][WIDTH-1:0]   s_nxt;
   logic [STAGES-1:0]              c_nxt;
   logic [CW:0]                    chunk_add;

   logic                           adv;

   // One enable for the whole pipe: it moves whenever the output slot is
   // empty or is being emptied this cycle. Holding every rank together keeps
   // result order and makes Sum/Cout stable under backpressure.
   assign adv       = ~v_q[STAGES] | out_ready;
   assign in_ready  = adv;
   assign out_valid = v_q[STAGES];
   assign Sum       = s_q[STAGES];
   assign Cout      = c_q[STAGES];

   // Stage k: chunk k of the operands plus the carry registered by the rank
   // before it. Lower sum chunks pass through; only chunk k is replaced.
   always_comb begin
      // NOTE: every always_comb output gets a default before the loop so no
      // path leaves it unassigned and no latch is inferred.
      s_nxt     = '0;
      c_nxt     = '0;
      chunk_add = '0;
      for (int k = 0; k < STAGES; k++) begin
         chunk_add = {1'b0, a_q[k][k*CW +: CW]}
                   + {1'b0, b_q[k][k*CW +: CW]}
                   + (CW+1)'(c_q[k]);
         s_nxt[k]              = s_q[k];
         s_nxt[k][k*CW +: CW]  = chunk_add[CW-1:0];
         c_nxt[k]              = chunk_add[CW];
      end
   end

   // NOTE: pipeline state uses non-blocking assignments so every rank samples
   // the previous rank's old value at the same edge. All ranks are plain
   // flops (not a memory), so each one is given an async reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         c_q <= '0;
         s_q <= '0;
         a_q <= '0;
         b_q <= '0;
      end else if (adv) begin
         // Input rank. Data is captured even for a bubble; valid=0 marks it
         // as carrying no result.
         v_q[0] <= in_valid;
         c_q[0] <= Cin;
         s_q[0] <= '0;
         a_q[0] <= A;
         b_q[0] <= B;
         for (int k = 0; k < STAGES; k++) begin
            v_q[k+1] <= v_q[k];
            c_q[k+1] <= c_nxt[k];
            s_q[k+1] <= s_nxt[k];
         end
         for (int k = 0; k < STAGES - 1; k++) begin
            a_q[k+1] <= a_q[k];
            b_q[k+1] <= b_q[k];
         end
      end
   end

`ifdef ADD_OVF_EN
   // Signed overflow = carry into the MSB xor carry out of the MSB. The carry
   // into the MSB is recovered from the MSB sum bit: c_in = a ^ b ^ s.
   logic ovf_nxt;
   logic ovf_q;

   assign ovf_nxt = a_q[STAGES-1][WIDTH-1]
                  ^ b_q[STAGES-1][WIDTH-1]
                  ^ s_nxt[STAGES-1][WIDTH-1]
                  ^ c_nxt[STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= ovf_nxt;
      end
   end

   assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_carry_adder
//
// Self-checking bench for pipelined_carry_adder (WIDTH=16, STAGES=4).
// A reference model computes A+B+Cin with plain wide arithmetic at the
// moment an operand is accepted and queues the result; every output
// transfer is compared against the queue head.
// ---------------------------------------------------------------------------
module tb_pipelined_carry_adder;

   localparam int W  = 16;
   localparam int ST = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] Sum;
   logic         Cout;
`ifdef ADD_OVF_EN
   logic         Ovf;
`endif

   pipelined_carry_adder #(.WIDTH(W), .STAGES(ST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
`ifdef ADD_OVF_EN
      .Cout      (Cout),
      .Ovf       (Ovf)
`else
      .Cout      (Cout)
`endif
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   exp_t q[$];
   int   out_cyc[$];
   int   cyc      = 0;
   int   n_tests  = 0;
   int   n_fail   = 0;
   logic last_acc = 1'b0;

   // Reference: exact (W+1)-bit sum; signed overflow when both operands share
   // a sign and the result sign differs.
   function automatic exp_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin);
      exp_t       e;
      logic [W:0] full;
      full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: observe the handshake at the falling edge, update the
   // model, then step past the rising edge.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      last_acc = 1'b0;
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
         out_cyc.push_back(cyc);
         check("result_expected", 32'(q.size() != 0), 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("sum", Sum, e.sum);
            check("cout", Cout, e.cout);
`ifdef ADD_OVF_EN
            check("ovf", Ovf, e.ovf);
`endif
         end
      end
      if (in_valid && in_ready) begin
         q.push_back(ref_add(A, B, Cin));
         last_acc = 1'b1;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // Present one operand and keep it until accepted (bounded).
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      A        = a;
      B        = b;
      Cin      = cin;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (last_acc) break;
      end
      check("send_accepted", last_acc, 1);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && q.size() != 0; i++) cycle();
      check("drain_empty", q.size(), 0);
      repeat (6) cycle();
   endtask

   // Single op on an empty pipe: out_valid must rise exactly ST edges later.
   task automatic latency_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      out_ready = 1'b1;
      send(a, b, cin);
      in_valid = 1'b0;
      for (int i = 1; i <= ST; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("latency_edge%0d", i), out_valid, (i == ST) ? 1 : 0);
      end
      cycle();
      check("latency_popped", q.size(), 0);
   endtask

   initial begin
      logic [W-1:0] s0;
      logic         c0;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      A         = '0;
      B         = '0;
      Cin       = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", Sum, 0);
      check("rst_cout", Cout, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);

      // 1: simple add with exact latency
      latency_op(16'h0001, 16'h0002, 1'b0);

      // 2: full carry propagation and a mixed pattern
      send(16'hFFFF, 16'h0001, 1'b0);
      send(16'h0F0F, 16'h00F1, 1'b1);
      drain();

      // 3: 8 back-to-back ops, results on consecutive cycles
      out_cyc.delete();
      for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 1'($urandom));
      drain();
      check("b2b_count", out_cyc.size(), 8);
      if (out_cyc.size() == 8) check("b2b_consecutive", out_cyc[7] - out_cyc[0], 7);

      // 4: fill the pipe with out_ready=0, then stall 3 cycles
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         A   = W'($urandom);
         B   = W'($urandom);
         Cin = 1'($urandom);
         cycle();
         if (!in_ready) break;
      end
      check("fill_stalled", in_ready, 0);
      check("fill_out_valid", out_valid, 1);
      s0 = Sum;
      c0 = Cout;
      if (q.size() != 0) check("stall_head", Sum, q[0].sum);
      for (int i = 0; i < 3; i++) begin
         A = W'($urandom);
         B = W'($urandom);
         cycle();
         check("stall_in_ready", in_ready, 0);
         check("stall_sum_hold", Sum, s0);
         check("stall_cout_hold", Cout, c0);
      end
      drain();

      // 5: reset with operations in flight
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(W'($urandom), W'($urandom), 1'($urandom));
      check("pre_rst_valid", out_valid, 1);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_sum", Sum, 0);
      check("midrst_cout", Cout, 0);
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      check("midrst_hold_valid", out_valid, 0);
      rst_n = 1'b1;
      latency_op(W'($urandom), W'($urandom), 1'b1);
      drain();

`ifdef ADD_OVF_EN
      // 6: signed overflow cases
      send(16'h7FFF, 16'h0001, 1'b0);
      send(16'h8000, 16'h8000, 1'b0);
      send(16'h0001, 16'h0001, 1'b0);
      drain();
`endif

      // Random traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         A         = W'($urandom);
         B         = W'($urandom);
         Cin       = 1'($urandom);
         cycle();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
